// File: rtl/serial_ule_compare_if.sv
// serial_ule_compare_if: operand/result valid-ready bundle for serial_ule_compare.
interface serial_ule_compare_if #(parameter int width = 8);
  logic [width-1:0] I0, I1;
  logic in_valid, in_ready, O, EQ, out_valid, out_ready;
  modport master(output I0, I1, in_valid, out_ready, input in_ready, O, EQ, out_valid);
  modport slave(input I0, I1, in_valid, out_ready, output in_ready, O, EQ, out_valid);
endinterface

// File: rtl/serial_ule_compare.sv
// serial_ule_compare: digit-serial MSB-first unsigned I0<=I1 / I0==I1 compare.
// Define SERIAL_ULE_COMPARE_EARLY_EXIT_EN to leave SCAN on the first differing digit.
module serial_ule_compare #(
  parameter int width = 8,
  parameter int digit = 1
) (
  input logic CLK,
  input logic ASYNCRESET,
  serial_ule_compare_if.slave bus
);
  localparam int N = width / digit;
  localparam int SW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [width-1:0] a_q, a_d, b_q, b_d;
  logic [SW-1:0] step_q, step_d;
  logic decided_q, decided_d, le_q, le_d, eq_q, eq_d;
  logic o_q, o_d, eq_out_q, eq_out_d, out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic [digit-1:0] a_dig, b_dig;
  logic hit, last, accept;
  assign a_dig = a_q[width-1 -: digit];
  assign b_dig = b_q[width-1 -: digit];
  assign hit = !decided_q && a_dig != b_dig;
  assign last = step_q == SW'(N - 1);
  assign accept = out_valid_q && bus.out_ready;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    step_d = step_q;
    decided_d = decided_q;
    le_d = le_q;
    eq_d = eq_q;
    o_d = o_q;
    eq_out_d = eq_out_q;
    if (state_q == IDLE && bus.in_valid && in_ready_q) begin
      a_d = bus.I0;
      b_d = bus.I1;
      step_d = '0;
      decided_d = 1'b0;
      le_d = 1'b1;
      eq_d = 1'b1;
      state_d = SCAN;
    end
    if (state_q == SCAN) begin
      a_d = a_q << digit;
      b_d = b_q << digit;
      step_d = step_q + 1'b1;
      if (hit) begin
        decided_d = 1'b1;
        le_d = a_dig < b_dig;
        eq_d = 1'b0;
      end
`ifdef SERIAL_ULE_COMPARE_EARLY_EXIT_EN
      state_d = last || hit ? DONE : SCAN;
`else
      state_d = last ? DONE : SCAN;
`endif
    end
    // Result flops load in DONE; le/eq no longer change there, so O/EQ hold steady.
    if (state_q == DONE) begin
      o_d = le_q;
      eq_out_d = eq_q;
      state_d = accept ? IDLE : DONE;
    end
    out_valid_d = state_q == DONE && !accept;
    in_ready_d = state_d == IDLE;
  end
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      step_q <= '0;
      decided_q <= 1'b0;
      le_q <= 1'b0;
      eq_q <= 1'b0;
      o_q <= 1'b0;
      eq_out_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      step_q <= step_d;
      decided_q <= decided_d;
      le_q <= le_d;
      eq_q <= eq_d;
      o_q <= o_d;
      eq_out_q <= eq_out_d;
      out_valid_q <= out_valid_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.O = o_q;
  assign bus.EQ = eq_out_q;
  assign bus.out_valid = out_valid_q;
endmodule
